// File: rtl/decode_issue.sv
// Purpose: MIPS decode stage; splits the instruction, reads the 32x32 regfile, builds execute controls into ID/EX.
// Latency: one cycle from a valid instruction in IF/ID to the registered execute-stage outputs.
// Backpressure: Stall (combinational) asks IF/ID and PC to hold for one cycle on a load-use hazard; a bubble is issued meanwhile.
module decode_issue #(
   parameter bit BYPASS_WB      = 1'b1,
   parameter bit LOAD_USE_STALL = 1'b1
) (
   input  logic        clock,
   input  logic        rst_n,
   input  logic        Id_valid,
   input  logic [31:0] Instruction,
   input  logic [31:0] PC_in,
   input  logic        Wb_en,
   input  logic [4:0]  Wb_addr,
   input  logic [31:0] Wb_data,
   input  logic        Flush,
   output logic        Stall,
   output logic        Ex_valid,
   output logic [31:0] Read_data_1,
   output logic [31:0] Read_data_2,
   output logic [31:0] Imme_extend,
   output logic [5:0]  Function_opcode,
   output logic [5:0]  opcode,
   output logic [4:0]  Shamt,
   output logic [31:0] PC,
   output logic [1:0]  ALUOp,
   output logic        ALUSrc,
   output logic        I_format,
   output logic        Sftmd,
   output logic        Jr,
   output logic [7:0]  Ex_ctrl,
   output logic [4:0]  Dest_reg
);

   // Bit position of MemRead inside Ex_ctrl {RegWrite,MemRead,MemWrite,MemtoReg,Branch,nBranch,Jmp,Jal}
   localparam int EX_MEMREAD = 6;

   logic [31:0] regs [0:31];

   logic [5:0]  op;
   logic [5:0]  funct;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [4:0]  shamt_d;
   logic [31:0] rs_val;
   logic [31:0] rt_val;

   logic        r_fmt;
   logic        i_fmt;
   logic        is_lw;
   logic        is_sw;
   logic        is_beq;
   logic        is_bne;
   logic        is_j;
   logic        is_jal;
   logic        jr_d;
   logic        sftmd_d;
   logic        zext;
   logic        reg_write;
   logic [31:0] imm_d;
   logic [7:0]  ctrl_d;
   logic [4:0]  dest_d;
   logic        hazard;
   logic        load;

   assign op      = Instruction[31:26];
   assign rs      = Instruction[25:21];
   assign rt      = Instruction[20:16];
   assign rd      = Instruction[15:11];
   assign shamt_d = Instruction[10:6];
   assign funct   = Instruction[5:0];

   assign r_fmt   = (op == 6'h00);
   assign i_fmt   = (op[5:3] == 3'b001);
   assign is_lw   = (op == 6'h23);
   assign is_sw   = (op == 6'h2B);
   assign is_beq  = (op == 6'h04);
   assign is_bne  = (op == 6'h05);
   assign is_j    = (op == 6'h02);
   assign is_jal  = (op == 6'h03);
   assign jr_d    = r_fmt && (funct == 6'h08);
   assign sftmd_d = r_fmt && (funct[5:3] == 3'b000);

   // Logical immediates (andi/ori/xori) zero-extend; everything else, lui included, sign-extends.
   assign zext  = (op == 6'h0C) || (op == 6'h0D) || (op == 6'h0E);
   assign imm_d = zext ? {16'h0000, Instruction[15:0]} : {{16{Instruction[15]}}, Instruction[15:0]};

   assign reg_write = (r_fmt && !jr_d) || i_fmt || is_lw || is_jal;
   assign ctrl_d    = {reg_write, is_lw, is_sw, is_lw, is_beq, is_bne, is_j, is_jal};
   assign dest_d    = is_jal ? 5'd31 : (r_fmt ? rd : rt);

   // rs read port: $0 is hard zero, same-cycle writeback optionally wins over the array.
   always_comb begin
      rs_val = 32'h0;
      if (rs != 5'd0) begin
         if (BYPASS_WB && Wb_en && (Wb_addr == rs)) rs_val = Wb_data;
         else                                       rs_val = regs[rs];
      end
   end

   // rt read port: same rules as rs.
   always_comb begin
      rt_val = 32'h0;
      if (rt != 5'd0) begin
         if (BYPASS_WB && Wb_en && (Wb_addr == rt)) rt_val = Wb_data;
         else                                       rt_val = regs[rt];
      end
   end

   // A load in EX whose target feeds this instruction; rt only counts when it is a true source.
   assign hazard = LOAD_USE_STALL && Id_valid && Ex_valid && Ex_ctrl[EX_MEMREAD] &&
                   (Dest_reg != 5'd0) &&
                   ((Dest_reg == rs) || ((Dest_reg == rt) && (r_fmt || is_beq || is_bne || is_sw)));

   // A resolved branch squashes the instruction anyway, so there is no point holding it.
   assign Stall = hazard && !Flush;
   assign load  = Id_valid && !Flush && !Stall;

   // Register file: cleared by reset, written on the edge; writes to $0 are dropped.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
      end else if (Wb_en && (Wb_addr != 5'd0)) begin
         regs[Wb_addr] <= Wb_data;
      end
   end

   // ID/EX register: decoded values when issuing, an all-zero bubble otherwise.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         Ex_valid        <= 1'b0;
         Read_data_1     <= 32'h0;
         Read_data_2     <= 32'h0;
         Imme_extend     <= 32'h0;
         Function_opcode <= 6'h0;
         opcode          <= 6'h0;
         Shamt           <= 5'h0;
         PC              <= 32'h0;
         ALUOp           <= 2'b00;
         ALUSrc          <= 1'b0;
         I_format        <= 1'b0;
         Sftmd           <= 1'b0;
         Jr              <= 1'b0;
         Ex_ctrl         <= 8'h00;
         Dest_reg        <= 5'h0;
      end else if (!load) begin
         Ex_valid        <= 1'b0;
         Read_data_1     <= 32'h0;
         Read_data_2     <= 32'h0;
         Imme_extend     <= 32'h0;
         Function_opcode <= 6'h0;
         opcode          <= 6'h0;
         Shamt           <= 5'h0;
         PC              <= 32'h0;
         ALUOp           <= 2'b00;
         ALUSrc          <= 1'b0;
         I_format        <= 1'b0;
         Sftmd           <= 1'b0;
         Jr              <= 1'b0;
         Ex_ctrl         <= 8'h00;
         Dest_reg        <= 5'h0;
      end else begin
         Ex_valid        <= 1'b1;
         Read_data_1     <= rs_val;
         Read_data_2     <= rt_val;
         Imme_extend     <= imm_d;
         Function_opcode <= funct;
         opcode          <= op;
         Shamt           <= shamt_d;
         PC              <= PC_in;
         ALUOp           <= {r_fmt || i_fmt, is_beq || is_bne};
         ALUSrc          <= i_fmt || is_lw || is_sw;
         I_format        <= i_fmt;
         Sftmd           <= sftmd_d;
         Jr              <= jr_d;
         Ex_ctrl         <= ctrl_d;
         Dest_reg        <= dest_d;
      end
   end

endmodule

// File: tb/tb_decode_issue.sv
// Bench for decode_issue: directed vector table, reset corner case, then random traffic vs a reference model.
// Latency: expects registered outputs one edge after inputs are applied.
// Backpressure: holds the IF/ID instruction for a cycle whenever the model predicts a stall.
module tb_decode_issue;

   logic        clock = 1'b0;
   logic        rst_n = 1'b0;
   logic        Id_valid = 1'b0;
   logic [31:0] Instruction = 32'h0;
   logic [31:0] PC_in = 32'h0;
   logic        Wb_en = 1'b0;
   logic [4:0]  Wb_addr = 5'h0;
   logic [31:0] Wb_data = 32'h0;
   logic        Flush = 1'b0;
   logic        Stall;
   logic        Ex_valid;
   logic [31:0] Read_data_1;
   logic [31:0] Read_data_2;
   logic [31:0] Imme_extend;
   logic [5:0]  Function_opcode;
   logic [5:0]  opcode;
   logic [4:0]  Shamt;
   logic [31:0] PC;
   logic [1:0]  ALUOp;
   logic        ALUSrc;
   logic        I_format;
   logic        Sftmd;
   logic        Jr;
   logic [7:0]  Ex_ctrl;
   logic [4:0]  Dest_reg;

   decode_issue dut (
      .clock(clock), .rst_n(rst_n), .Id_valid(Id_valid), .Instruction(Instruction),
      .PC_in(PC_in), .Wb_en(Wb_en), .Wb_addr(Wb_addr), .Wb_data(Wb_data), .Flush(Flush),
      .Stall(Stall), .Ex_valid(Ex_valid), .Read_data_1(Read_data_1), .Read_data_2(Read_data_2),
      .Imme_extend(Imme_extend), .Function_opcode(Function_opcode), .opcode(opcode),
      .Shamt(Shamt), .PC(PC), .ALUOp(ALUOp), .ALUSrc(ALUSrc), .I_format(I_format),
      .Sftmd(Sftmd), .Jr(Jr), .Ex_ctrl(Ex_ctrl), .Dest_reg(Dest_reg)
   );

   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        valid;
      logic [31:0] rd1, rd2, imm, pc;
      logic [5:0]  funct, op;
      logic [4:0]  shamt;
      logic [1:0]  aluop;
      logic        alusrc, ifmt, sftmd, jr;
      logic [7:0]  ctrl;
      logic [4:0]  dest;
   } ex_t;

   typedef struct {
      logic [31:0] ins;
      logic        idv, wen;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        fl;
      logic        e_st, e_valid;
      logic [31:0] e_rd1, e_imm;
      logic [4:0]  e_dest;
      logic [7:0]  e_ctrl;
   } vec_t;

   ex_t         m_ex;
   logic [31:0] m_regs [32];
   vec_t        tbl [18];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic ex_t bubble();
      ex_t e;
      e = '{default: '0};
      return e;
   endfunction

   function automatic logic [31:0] rdreg(input logic [4:0] a);
      if (a == 5'd0) return 32'h0;
      if (Wb_en && Wb_addr == a) return Wb_data;
      return m_regs[a];
   endfunction

   // Reference decode, written per instruction class.
   function automatic ex_t decode(input logic [31:0] ins, input logic [31:0] pc);
      ex_t        e;
      logic [5:0] op;
      logic [5:0] f;
      bit r = 0, itype = 0, lw = 0, sw = 0, beq = 0, bne = 0, j = 0, jal = 0;
      op = ins[31:26];
      f  = ins[5:0];
      case (op)
         6'h00:   r = 1;
         6'h23:   lw = 1;
         6'h2B:   sw = 1;
         6'h04:   beq = 1;
         6'h05:   bne = 1;
         6'h02:   j = 1;
         6'h03:   jal = 1;
         default: itype = (op >= 6'h08 && op <= 6'h0F);
      endcase
      e.valid  = 1'b1;
      e.rd1    = rdreg(ins[25:21]);
      e.rd2    = rdreg(ins[20:16]);
      e.pc     = pc;
      e.funct  = f;
      e.op     = op;
      e.shamt  = ins[10:6];
      if (op == 6'h0C || op == 6'h0D || op == 6'h0E) e.imm = {16'h0, ins[15:0]};
      else e.imm = ins[15] ? (32'hFFFF0000 | {16'h0, ins[15:0]}) : {16'h0, ins[15:0]};
      e.jr     = r && (f == 6'h08);
      e.sftmd  = r && (f < 6'd8);
      e.aluop  = {r | itype, beq | bne};
      e.alusrc = itype | lw | sw;
      e.ifmt   = itype;
      e.ctrl   = {(r && !e.jr) || itype || lw || jal, lw, sw, lw, beq, bne, j, jal};
      e.dest   = jal ? 5'd31 : (r ? ins[15:11] : ins[20:16]);
      return e;
   endfunction

   function automatic logic model_stall(input logic [31:0] ins, input logic idv, input logic fl);
      logic load_in_ex;
      logic uses_rt;
      load_in_ex = m_ex.valid && m_ex.ctrl[6] && (m_ex.dest != 5'd0);
      uses_rt = (ins[31:26] == 6'h00) || (ins[31:26] == 6'h04) ||
                (ins[31:26] == 6'h05) || (ins[31:26] == 6'h2B);
      return idv && !fl && load_in_ex &&
             ((m_ex.dest == ins[25:21]) || (uses_rt && m_ex.dest == ins[20:16]));
   endfunction

   task automatic check_all(input string tag, input ex_t e);
      chk({tag, ".valid"}, {31'h0, Ex_valid}, {31'h0, e.valid});
      chk({tag, ".rd1"}, Read_data_1, e.rd1);
      chk({tag, ".rd2"}, Read_data_2, e.rd2);
      chk({tag, ".imm"}, Imme_extend, e.imm);
      chk({tag, ".pc"}, PC, e.pc);
      chk({tag, ".ctrl"}, {24'h0, Ex_ctrl}, {24'h0, e.ctrl});
      chk({tag, ".dest"}, {27'h0, Dest_reg}, {27'h0, e.dest});
      chk({tag, ".fields"},
          {9'h0, Function_opcode, opcode, Shamt, ALUOp, ALUSrc, I_format, Sftmd, Jr},
          {9'h0, e.funct, e.op, e.shamt, e.aluop, e.alusrc, e.ifmt, e.sftmd, e.jr});
   endtask

   // Called just after a rising edge: apply inputs, check Stall, advance the model, check ID/EX.
   task automatic cycle(input logic [31:0] ins, input logic [31:0] pc, input logic idv,
                        input logic wen, input logic [4:0] wa, input logic [31:0] wd,
                        input logic fl, output logic act_st);
      logic exp_st;
      ex_t  nxt;
      Instruction = ins; PC_in = pc; Id_valid = idv;
      Wb_en = wen; Wb_addr = wa; Wb_data = wd; Flush = fl;
      #1;
      exp_st = model_stall(ins, idv, fl);
      act_st = Stall;
      chk("stall", {31'h0, Stall}, {31'h0, exp_st});
      if (!idv || fl || exp_st) nxt = bubble();
      else nxt = decode(ins, pc);
      @(posedge clock);
      m_ex = nxt;
      if (wen && wa != 5'd0) m_regs[wa] = wd;
      #1;
      check_all("cyc", m_ex);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, limit 200000");
      $fatal(1);
   end

   initial begin
      logic        st;
      logic [31:0] ins;
      logic [31:0] pc;
      logic [5:0]  ops [12];
      logic [5:0]  fns [5];

      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_ex = bubble();

      //           ins           idv  wen wa     wd            fl   st   vld  rd1           imm           dest    ctrl
      tbl[0]  = '{32'h00000000, 1'b0, 1'b1, 5'd1, 32'h10,       1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        5'd0,  8'h00};
      tbl[1]  = '{32'h2022FFFC, 1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h10,       32'hFFFFFFFC, 5'd2,  8'h80};
      tbl[2]  = '{32'h34038000, 1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0,        32'h00008000, 5'd3,  8'h80};
      tbl[3]  = '{32'h0C000010, 1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0,        32'h00000010, 5'd31, 8'h81};
      tbl[4]  = '{32'h8C240000, 1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h10,       32'h0,        5'd4,  8'hD0};
      tbl[5]  = '{32'h00842820, 1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        32'h0,        5'd0,  8'h00};
      tbl[6]  = '{32'h00842820, 1'b1, 1'b1, 5'd4, 32'h55,       1'b0, 1'b0, 1'b1, 32'h55,       32'h00002820, 5'd5,  8'h80};
      tbl[7]  = '{32'h00E04020, 1'b1, 1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 32'h00004020, 5'd8,  8'h80};
      tbl[8]  = '{32'h00004820, 1'b1, 1'b1, 5'd0, 32'h1234,     1'b0, 1'b0, 1'b1, 32'h0,        32'h00004820, 5'd9,  8'h80};
      tbl[9]  = '{32'h8C240000, 1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h10,       32'h0,        5'd4,  8'hD0};
      tbl[10] = '{32'h00842820, 1'b1, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        5'd0,  8'h00};
      tbl[11] = '{32'h8C240000, 1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h10,       32'h0,        5'd4,  8'hD0};
      tbl[12] = '{32'h00842820, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        5'd0,  8'h00};
      tbl[13] = '{32'h8C240000, 1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h10,       32'h0,        5'd4,  8'hD0};
      tbl[14] = '{32'h20440001, 1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0,        32'h00000001, 5'd4,  8'h80};
      tbl[15] = '{32'h8C240000, 1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h10,       32'h0,        5'd4,  8'hD0};
      tbl[16] = '{32'hAC240000, 1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        32'h0,        5'd0,  8'h00};
      tbl[17] = '{32'hAC240000, 1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h10,       32'h0,        5'd4,  8'h20};

      // Reset state, asserted asynchronously at time 0.
      #1;
      chk("reset.stall", {31'h0, Stall}, 32'h0);
      check_all("reset", bubble());
      @(posedge clock);
      #1;
      rst_n = 1'b1;

      // Directed vectors.
      for (int i = 0; i < 18; i++) begin
         cycle(tbl[i].ins, 32'h100 + 32'(i * 4), tbl[i].idv, tbl[i].wen, tbl[i].wa,
               tbl[i].wd, tbl[i].fl, st);
         chk($sformatf("tbl%0d.stall", i), {31'h0, st}, {31'h0, tbl[i].e_st});
         chk($sformatf("tbl%0d.valid", i), {31'h0, Ex_valid}, {31'h0, tbl[i].e_valid});
         chk($sformatf("tbl%0d.rd1", i), Read_data_1, tbl[i].e_rd1);
         chk($sformatf("tbl%0d.imm", i), Imme_extend, tbl[i].e_imm);
         chk($sformatf("tbl%0d.dest", i), {27'h0, Dest_reg}, {27'h0, tbl[i].e_dest});
         chk($sformatf("tbl%0d.ctrl", i), {24'h0, Ex_ctrl}, {24'h0, tbl[i].e_ctrl});
      end

      // Asynchronous reset mid-stream while ID/EX holds a valid instruction.
      cycle(32'h2022FFFC, 32'h200, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, st);
      chk("pre_reset.valid", {31'h0, Ex_valid}, 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_ex = bubble();
      check_all("midreset", m_ex);
      chk("midreset.stall", {31'h0, Stall}, 32'h0);
      @(posedge clock);
      #1;
      rst_n = 1'b1;
      cycle(32'h00E04020, 32'h204, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, st);
      chk("post_reset.rd1", Read_data_1, 32'h0);
      cycle(32'h2022FFFC, 32'h208, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, st);
      chk("post_reset.r1", Read_data_1, 32'h0);

      // Random traffic with a narrow register range to provoke hazards and bypasses.
      ops = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};
      fns = '{6'h20, 6'h22, 6'h00, 6'h08, 6'h2A};
      st  = 1'b0;
      ins = 32'h0;
      pc  = 32'h1000;
      for (int n = 0; n < 400; n++) begin
         if (!st) begin
            logic [5:0] op;
            logic [5:0] fn;
            op = ops[$urandom_range(0, 11)];
            fn = ($urandom_range(0, 5) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
            ins = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 5'($urandom), fn};
            if (op != 6'h00) ins[15:0] = 16'($urandom);
            pc = pc + 32'd4;
         end
         cycle(ins, pc, $urandom_range(0, 9) != 0, 1'($urandom), 5'($urandom_range(0, 7)),
               $urandom, $urandom_range(0, 7) == 0, st);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
